// File: rtl/ddr_arb_pkg.sv
// Shared constants for the DDR2 request arbiter: MIG command encodings and a
// constant-evaluable ceil(log2) helper used for parameter-derived widths.
package ddr_arb_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] DDR_CMD_WRITE = 3'b000;
  localparam logic [CMD_W-1:0] DDR_CMD_READ  = 3'b001;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// Synchronous FIFO of client IDs, one entry per outstanding read command.
// DEPTH must be a power of two so the pointers wrap naturally.
module ddr_arb_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [ID_W-1:0]        push_id,
  input  logic                   pop,
  output logic [ID_W-1:0]        head_id,
  output logic                   empty,
  output logic                   full,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ID_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/ddr_req_arbiter.sv
// N-client arbiter in front of the MIG af/wdf/rdf FIFOs with read tagging.
// Define DDR_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ddr_req_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 31,
  parameter int DATA_W      = 128,
  parameter int MASK_W      = 16,
  parameter int WR_BEATS    = 2,
  parameter int RD_BEATS    = 2,
  parameter int TAG_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        cl_af_wr_en,
  input  logic [NUM_CLIENTS*CMD_W-1:0]  cl_af_cmd_din,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_af_addr_din,
  output logic [NUM_CLIENTS-1:0]        cl_af_full,
  input  logic [NUM_CLIENTS-1:0]        cl_wdf_wr_en,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdf_din,
  input  logic [NUM_CLIENTS*MASK_W-1:0] cl_wdf_mask_din,
  output logic [NUM_CLIENTS-1:0]        cl_wdf_full,
  input  logic [NUM_CLIENTS-1:0]        cl_rdf_rd_en,
  output logic [NUM_CLIENTS-1:0]        cl_rdf_valid,
  input  logic                          af_full,
  input  logic                          wdf_full,
  input  logic                          rdf_valid,
  output logic                          af_wr_en,
  output logic [CMD_W-1:0]              af_cmd_din,
  output logic [ADDR_W-1:0]             af_addr_din,
  output logic                          wdf_wr_en,
  output logic [DATA_W-1:0]             wdf_din,
  output logic [MASK_W-1:0]             wdf_mask_din,
  output logic                          rdf_rd_en,
  output logic [clog2(TAG_DEPTH):0]     tag_count,
  output logic                          orphan_err,
  output logic [0:0]                    arb_state
);

  // Handshake: a push (af/wdf) or pop (rdf) transfers on any cycle where the
  // enable is high and the matching full is low (valid is high for rdf); the
  // client must hold its enable and payload stable until that cycle.

  localparam int ID_W = clog2(NUM_CLIENTS);
  localparam int WBW  = clog2(WR_BEATS + 1);
  localparam int RBW  = clog2(RD_BEATS + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]      state;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] sel;
  logic            cmd_done;
  logic [WBW-1:0]  wbeats;
  logic [WBW-1:0]  wbeats_nxt;
  logic [RBW-1:0]  rbeats;

  logic              g_af_wr_en;
  logic [CMD_W-1:0]  g_cmd;
  logic [ADDR_W-1:0] g_addr;
  logic              g_wdf_wr_en;
  logic [DATA_W-1:0] g_data;
  logic [MASK_W-1:0] g_mask;

  logic              in_grant;
  logic              wbeats_full;
  logic              cmd_acc;
  logic              wdf_acc;
  logic              is_read;
  logic              rd_issue;
  logic              wr_done;
  logic              arb_go;

  logic [ID_W-1:0]   tag_head;
  logic              tag_empty;
  logic              tag_full;
  logic              tag_pop;
  logic              head_rd_en;
  logic              beat_pop;

  assign arb_state = state;
  assign in_grant  = (state == ST_GRANT);

  // Pick out the current grantee's request fields.
  always_comb begin
    g_af_wr_en  = 1'b0;
    g_cmd       = '0;
    g_addr      = '0;
    g_wdf_wr_en = 1'b0;
    g_data      = '0;
    g_mask      = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant == ID_W'(i)) begin
        g_af_wr_en  = cl_af_wr_en[i];
        g_cmd       = cl_af_cmd_din[i*CMD_W +: CMD_W];
        g_addr      = cl_af_addr_din[i*ADDR_W +: ADDR_W];
        g_wdf_wr_en = cl_wdf_wr_en[i];
        g_data      = cl_wdf_din[i*DATA_W +: DATA_W];
        g_mask      = cl_wdf_mask_din[i*MASK_W +: MASK_W];
      end
    end
  end

`ifdef DDR_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (cl_af_wr_en[i]) sel = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] last_grant;

  // Lowest requester overall is the wrap-around fallback; the lowest one
  // above the last grantee overrides it.
  always_comb begin
    sel = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (cl_af_wr_en[i]) sel = ID_W'(i);
    end
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (cl_af_wr_en[i] && (i > int'(last_grant))) sel = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_CLIENTS - 1);
    end else if (arb_go) begin
      last_grant <= sel;
    end
  end
`endif

  assign wbeats_full = (wbeats == WBW'(WR_BEATS));
  assign af_wr_en    = in_grant & g_af_wr_en & ~cmd_done;
  assign af_cmd_din  = g_cmd;
  assign af_addr_din = g_addr;
  assign wdf_wr_en   = in_grant & g_wdf_wr_en & ~wbeats_full;
  assign wdf_din     = g_data;
  assign wdf_mask_din = g_mask;

  assign cmd_acc    = af_wr_en & ~af_full;
  assign wdf_acc    = wdf_wr_en & ~wdf_full;
  assign is_read    = (g_cmd == DDR_CMD_READ);
  assign rd_issue   = cmd_acc & is_read;
  assign wbeats_nxt = wbeats + WBW'(wdf_acc);
  // Data beats may land before, with or after the command.
  assign wr_done    = (cmd_done | (cmd_acc & ~is_read)) & (wbeats_nxt == WBW'(WR_BEATS));
  assign arb_go     = (state == ST_IDLE) & (|cl_af_wr_en) & ~tag_full;

  always_comb begin
    cl_af_full  = '1;
    cl_wdf_full = '1;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (in_grant && (grant == ID_W'(i))) begin
        cl_af_full[i]  = af_full | cmd_done;
        cl_wdf_full[i] = wdf_full | wbeats_full;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      cmd_done <= 1'b0;
      wbeats   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_go) begin
            grant <= sel;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (wdf_acc) wbeats <= wbeats_nxt;
          if (cmd_acc && !is_read) cmd_done <= 1'b1;
          if (rd_issue || wr_done) begin
            state    <= ST_IDLE;
            cmd_done <= 1'b0;
            wbeats   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read return path: the head tag owns the rdf until RD_BEATS beats pop.
  always_comb begin
    cl_rdf_valid = '0;
    head_rd_en   = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (tag_head == ID_W'(i)) begin
        cl_rdf_valid[i] = rdf_valid & ~tag_empty;
        head_rd_en      = cl_rdf_rd_en[i];
      end
    end
    rdf_rd_en = tag_empty ? rdf_valid : (head_rd_en & rdf_valid);
  end

  assign beat_pop = rdf_rd_en & ~tag_empty;
  assign tag_pop  = beat_pop & (rbeats == RBW'(RD_BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbeats     <= '0;
      orphan_err <= 1'b0;
    end else begin
      if (beat_pop) rbeats <= tag_pop ? '0 : rbeats + 1'b1;
      if (rdf_valid && tag_empty) orphan_err <= 1'b1;
    end
  end

  ddr_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .ID_W  (ID_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (rd_issue),
    .push_id (grant),
    .pop     (tag_pop),
    .head_id (tag_head),
    .empty   (tag_empty),
    .full    (tag_full),
    .count   (tag_count)
  );

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed bench for ddr_req_arbiter (default parameters, round-robin build).
module tb_ddr_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 31;
  localparam int DW = 128;
  localparam int MW = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    cl_af_wr_en;
  logic [N*3-1:0]  cl_af_cmd_din;
  logic [N*AW-1:0] cl_af_addr_din;
  logic [N-1:0]    cl_af_full;
  logic [N-1:0]    cl_wdf_wr_en;
  logic [N*DW-1:0] cl_wdf_din;
  logic [N*MW-1:0] cl_wdf_mask_din;
  logic [N-1:0]    cl_wdf_full;
  logic [N-1:0]    cl_rdf_rd_en;
  logic [N-1:0]    cl_rdf_valid;
  logic            af_full;
  logic            wdf_full;
  logic            rdf_valid;
  logic            af_wr_en;
  logic [2:0]      af_cmd_din;
  logic [AW-1:0]   af_addr_din;
  logic            wdf_wr_en;
  logic [DW-1:0]   wdf_din;
  logic [MW-1:0]   wdf_mask_din;
  logic            rdf_rd_en;
  logic [3:0]      tag_count;
  logic            orphan_err;
  logic [0:0]      arb_state;

  int total = 0;
  int bad   = 0;

  ddr_req_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cl_af_wr_en     (cl_af_wr_en),
    .cl_af_cmd_din   (cl_af_cmd_din),
    .cl_af_addr_din  (cl_af_addr_din),
    .cl_af_full      (cl_af_full),
    .cl_wdf_wr_en    (cl_wdf_wr_en),
    .cl_wdf_din      (cl_wdf_din),
    .cl_wdf_mask_din (cl_wdf_mask_din),
    .cl_wdf_full     (cl_wdf_full),
    .cl_rdf_rd_en    (cl_rdf_rd_en),
    .cl_rdf_valid    (cl_rdf_valid),
    .af_full         (af_full),
    .wdf_full        (wdf_full),
    .rdf_valid       (rdf_valid),
    .af_wr_en        (af_wr_en),
    .af_cmd_din      (af_cmd_din),
    .af_addr_din     (af_addr_din),
    .wdf_wr_en       (wdf_wr_en),
    .wdf_din         (wdf_din),
    .wdf_mask_din    (wdf_mask_din),
    .rdf_rd_en       (rdf_rd_en),
    .tag_count       (tag_count),
    .orphan_err      (orphan_err),
    .arb_state       (arb_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    cl_af_wr_en     = '0;
    cl_af_cmd_din   = '0;
    cl_af_addr_din  = '0;
    cl_wdf_wr_en    = '0;
    cl_wdf_din      = '0;
    cl_wdf_mask_din = '0;
    cl_rdf_rd_en    = '0;
    af_full         = 1'b0;
    wdf_full        = 1'b0;
    rdf_valid       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // driver tasks
  task automatic set_req(input int c, input logic en, input logic [2:0] cmd, input logic [AW-1:0] addr);
    cl_af_wr_en[c]             = en;
    cl_af_cmd_din[c*3 +: 3]    = cmd;
    cl_af_addr_din[c*AW +: AW] = addr;
  endtask

  task automatic set_wdf(input int c, input logic en, input logic [DW-1:0] d, input logic [MW-1:0] m);
    cl_wdf_wr_en[c]             = en;
    cl_wdf_din[c*DW +: DW]      = d;
    cl_wdf_mask_din[c*MW +: MW] = m;
  endtask

  localparam logic [2:0] RD = 3'b001;
  localparam logic [2:0] WR = 3'b000;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #3;
    chk("rst_af_full",   cl_af_full,   4'hf);
    chk("rst_wdf_full",  cl_wdf_full,  4'hf);
    chk("rst_rdf_valid", cl_rdf_valid, 4'h0);
    chk("rst_af_wr_en",  af_wr_en,     1'b0);
    chk("rst_wdf_wr_en", wdf_wr_en,    1'b0);
    chk("rst_rdf_rd_en", rdf_rd_en,    1'b0);
    chk("rst_tag_count", tag_count,    4'd0);
    chk("rst_orphan",    orphan_err,   1'b0);
    chk("rst_state",     arb_state,    1'b0);

    // client 1 read, two beats returned
    do_reset();
    set_req(1, 1'b1, RD, 31'h100);
    settle();
    chk("rd1_idle_full", cl_af_full, 4'hf);
    chk("rd1_idle_wr",   af_wr_en,   1'b0);
    step();
    chk("rd1_af_wr_en", af_wr_en,    1'b1);
    chk("rd1_cmd",      af_cmd_din,  3'b001);
    chk("rd1_addr",     af_addr_din, 31'h100);
    chk("rd1_full",     cl_af_full,  4'b1101);
    step();
    set_req(1, 1'b0, RD, 31'h100);
    settle();
    chk("rd1_tag1",  tag_count, 4'd1);
    chk("rd1_idle",  arb_state, 1'b0);
    rdf_valid    = 1'b1;
    cl_rdf_rd_en = 4'b1101;
    settle();
    chk("rd1_valid",      cl_rdf_valid, 4'b0010);
    chk("rd1_nonhead_rd", rdf_rd_en,    1'b0);
    cl_rdf_rd_en = 4'b1111;
    settle();
    chk("rd1_rd_en", rdf_rd_en, 1'b1);
    step();
    chk("rd1_beat1_tag", tag_count, 4'd1);
    step();
    rdf_valid    = 1'b0;
    cl_rdf_rd_en = '0;
    settle();
    chk("rd1_tag0",  tag_count,    4'd0);
    chk("rd1_valid0", cl_rdf_valid, 4'b0000);

    // round-robin: 0 and 2 together, then 0/1/3 -> 3 then 0
    do_reset();
    set_req(0, 1'b1, RD, 31'h10);
    set_req(2, 1'b1, RD, 31'h20);
    step();
    chk("rr_g0_full", cl_af_full,  4'b1110);
    chk("rr_g0_addr", af_addr_din, 31'h10);
    step();
    set_req(0, 1'b0, RD, 31'h10);
    step();
    chk("rr_g2_full", cl_af_full,  4'b1011);
    chk("rr_g2_addr", af_addr_din, 31'h20);
    step();
    set_req(2, 1'b0, RD, 31'h20);
    set_req(0, 1'b1, RD, 31'h30);
    set_req(1, 1'b1, RD, 31'h31);
    set_req(3, 1'b1, RD, 31'h33);
    step();
    chk("rr_g3_full", cl_af_full, 4'b0111);
    step();
    set_req(3, 1'b0, RD, 31'h33);
    step();
    chk("rr_wrap_g0", cl_af_full, 4'b1110);
    step();
    set_req(0, 1'b0, RD, 31'h30);
    set_req(1, 1'b0, RD, 31'h31);
    settle();
    chk("rr_tags", tag_count, 4'd4);
    rdf_valid    = 1'b1;
    cl_rdf_rd_en = 4'b1111;
    settle();
    chk("rr_route0", cl_rdf_valid, 4'b0001);
    step();
    step();
    chk("rr_route2", cl_rdf_valid, 4'b0100);
    rst_n = 1'b0;
    settle();
    chk("rr_rst_tags",  tag_count,    4'd0);
    chk("rr_rst_valid", cl_rdf_valid, 4'b0000);

    // client 3 write, data before command (af held full)
    do_reset();
    af_full = 1'b1;
    set_req(3, 1'b1, WR, 31'h200);
    set_wdf(3, 1'b1, 128'hd0d0, 16'h00ff);
    set_wdf(0, 1'b1, 128'hbad0, 16'hffff);
    step();
    chk("wr_wdf_en",   wdf_wr_en,   1'b1);
    chk("wr_wdf_d0",   wdf_din,     128'hd0d0);
    chk("wr_wdf_full", cl_wdf_full, 4'b0111);
    chk("wr_af_held",  cl_af_full,  4'hf);
    step();
    set_wdf(3, 1'b1, 128'hd1d1, 16'hff00);
    settle();
    chk("wr_wdf_d1",   wdf_din,      128'hd1d1);
    chk("wr_wdf_m1",   wdf_mask_din, 16'hff00);
    step();
    set_wdf(3, 1'b0, 128'h0, 16'h0);
    settle();
    chk("wr_beats_full", cl_wdf_full, 4'hf);
    chk("wr_wdf_off",    wdf_wr_en,   1'b0);
    chk("wr_still_gnt",  arb_state,   1'b1);
    af_full = 1'b0;
    settle();
    chk("wr_af_en",   af_wr_en,    1'b1);
    chk("wr_af_addr", af_addr_din, 31'h200);
    chk("wr_af_full", cl_af_full,  4'b0111);
    step();
    set_req(3, 1'b0, WR, 31'h200);
    set_wdf(0, 1'b0, 128'h0, 16'h0);
    settle();
    chk("wr_idle", arb_state, 1'b0);
    chk("wr_notag", tag_count, 4'd0);

    // nine reads against eight tags
    do_reset();
    set_req(0, 1'b1, RD, 31'h300);
    repeat (16) step();
    chk("tag_full_cnt", tag_count, 4'd8);
    chk("tag_full_st",  arb_state, 1'b0);
    repeat (2) step();
    chk("tag_block_st", arb_state,  1'b0);
    chk("tag_block_af", af_wr_en,   1'b0);
    rdf_valid    = 1'b1;
    cl_rdf_rd_en = 4'b0001;
    settle();
    chk("tag_ret_valid", cl_rdf_valid, 4'b0001);
    step();
    step();
    rdf_valid    = 1'b0;
    cl_rdf_rd_en = '0;
    settle();
    chk("tag_pop_cnt", tag_count, 4'd7);
    step();
    chk("tag_9th_gnt", arb_state, 1'b1);
    step();
    set_req(0, 1'b0, RD, 31'h300);
    settle();
    chk("tag_9th_cnt", tag_count, 4'd8);

    // orphan read beat
    do_reset();
    rdf_valid = 1'b1;
    settle();
    chk("orph_drain", rdf_rd_en,    1'b1);
    chk("orph_valid", cl_rdf_valid, 4'b0000);
    chk("orph_pre",   orphan_err,   1'b0);
    step();
    chk("orph_set", orphan_err, 1'b1);
    rdf_valid = 1'b0;
    step();
    chk("orph_sticky", orphan_err, 1'b1);
    rst_n = 1'b0;
    settle();
    chk("orph_clear", orphan_err, 1'b0);

    // af_full held during a read grant
    do_reset();
    af_full = 1'b1;
    set_req(2, 1'b1, RD, 31'h400);
    step();
    chk("afull_full", cl_af_full, 4'hf);
    chk("afull_gnt",  arb_state,  1'b1);
    repeat (3) step();
    chk("afull_held",  arb_state, 1'b1);
    chk("afull_notag", tag_count, 4'd0);
    af_full = 1'b0;
    settle();
    chk("afull_open", cl_af_full, 4'b1011);
    step();
    set_req(2, 1'b0, RD, 31'h400);
    settle();
    chk("afull_tag",  tag_count, 4'd1);
    chk("afull_idle", arb_state, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
